// File: rtl/backdoor_pkg.sv
// Shared definitions for the backdoor controller: FSM encoding, select bases,
// offset width and the saturating counter helper.
package backdoor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SYNC_WAIT = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_ACCESS    = 3'd3,
    ST_RESP      = 3'd4,
    ST_HOLD      = 3'd5
  } state_t;

  localparam logic [3:0] ROM_SEL_BASE = 4'h0;
  localparam logic [3:0] RAM_SEL_BASE = 4'h8;
  localparam int         OFFSET_W     = 12;
  localparam int         CNT_W        = 8;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/backdoor_decode.sv
// Maps the address select nibble onto a one-hot target vector (ROMs first,
// then RAMs) and flags whether the nibble hits any target.
module backdoor_decode
  import backdoor_pkg::*;
#(
  parameter int NUM_ROM = 5,
  parameter int NUM_RAM = 2
) (
  input  logic [3:0]                 sel,
  output logic [NUM_ROM+NUM_RAM-1:0] tgt_vec,
  output logic                       mapped
);

  logic [31:0] sel_ext_s;

  assign sel_ext_s = {28'd0, sel};

  // Compare the nibble against each target's select code.
  always_comb begin
    tgt_vec = '0;
    for (int k = 0; k < NUM_ROM; k++) begin
      tgt_vec[k] = (sel_ext_s == ({28'd0, ROM_SEL_BASE} + 32'(k)));
    end
    for (int k = 0; k < NUM_RAM; k++) begin
      tgt_vec[NUM_ROM+k] = (sel_ext_s == ({28'd0, RAM_SEL_BASE} + 32'(k)));
    end
    mapped = |tgt_vec;
  end

endmodule

// File: rtl/backdoor_ctrl.sv
// Wishbone debug slave that halts the CPU, aligns to an instruction boundary and
// forwards one transaction to a ROM/RAM backdoor. Optional macro: BACKDOOR_ERR_EN.
module backdoor_ctrl
  import backdoor_pkg::*;
#(
  parameter int NUM_ROM       = 5,
  parameter int NUM_RAM       = 2,
  parameter int SETTLE_CYCLES = 8,
  parameter int SYNC_TIMEOUT  = 64,
  parameter int ACK_TIMEOUT   = 32,
  parameter int HOLD_CYCLES   = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              sync,
  output logic                              halt,
  input  logic                              wb_cyc_i,
  input  logic                              wb_strobe_i,
  input  logic                              wb_we_i,
  input  logic [31:0]                       wb_addr_i,
  input  logic [31:0]                       wb_data_i,
  output logic [31:0]                       wb_data_o,
  output logic                              wb_ack_o,
`ifdef BACKDOOR_ERR_EN
  output logic                              wb_err_o,
`endif
  output logic [NUM_ROM+NUM_RAM-1:0]        tgt_cyc_o,
  output logic [NUM_ROM+NUM_RAM-1:0]        tgt_strobe_o,
  output logic                              tgt_we_o,
  output logic [31:0]                       tgt_addr_o,
  output logic [31:0]                       tgt_data_o,
  input  logic [32*(NUM_ROM+NUM_RAM)-1:0]   tgt_data_i,
  input  logic [NUM_ROM+NUM_RAM-1:0]        tgt_ack_i
);

  localparam int NT = NUM_ROM + NUM_RAM;
  localparam logic [CNT_W-1:0] SYNC_LAST   = CNT_W'(SYNC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST    = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

  state_t                state_r, state_nxt_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [OFFSET_W-1:0]   addr_r;
  logic                  we_r, mapped_r;
  logic [31:0]           wdata_r;
  logic [NT-1:0]         vec_r, dec_vec_s;
  logic                  dec_mapped_s, load_s, ack_hit_s, resp_err_s, resp_nxt_s, halt_nxt_s;
  logic [31:0]           rd_data_s, rdata_nxt_s, addr_nxt_s, wdata_nxt_s;
  logic [NT-1:0]         stb_nxt_s;
  logic                  we_nxt_s, ack_nxt_s;
  logic                  unused_addr_s;
`ifdef BACKDOOR_ERR_EN
  logic                  err_nxt_s;
`endif

  assign unused_addr_s = ^wb_addr_i[31:16];
  assign load_s    = ((state_r == ST_IDLE) || (state_r == ST_HOLD)) && wb_cyc_i && wb_strobe_i;
  assign ack_hit_s = |(tgt_ack_i & vec_r);

  backdoor_decode #(.NUM_ROM(NUM_ROM), .NUM_RAM(NUM_RAM)) u_decode (
    .sel     (wb_addr_i[15:12]),
    .tgt_vec (dec_vec_s),
    .mapped  (dec_mapped_s)
  );

  // Read-data mux: only the latched target's slice can reach the host.
  always_comb begin
    rd_data_s = '0;
    for (int k = 0; k < NT; k++) begin
      rd_data_s = rd_data_s | (tgt_data_i[32*k +: 32] & {32{vec_r[k]}});
    end
  end

  // Next-state logic; host abandonment takes priority over every wait.
  always_comb begin
    state_nxt_s = state_r;
    resp_err_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (load_s) state_nxt_s = ST_SYNC_WAIT;
        else        state_nxt_s = ST_IDLE;
      end
      ST_SYNC_WAIT: begin
        if (!wb_cyc_i)                            state_nxt_s = ST_HOLD;
        else if ((sync && halt) || (cnt_r == SYNC_LAST)) state_nxt_s = ST_SETTLE;
        else                                      state_nxt_s = ST_SYNC_WAIT;
      end
      ST_SETTLE: begin
        if (!wb_cyc_i)                  state_nxt_s = ST_HOLD;
        else if (cnt_r == SETTLE_LAST)  state_nxt_s = ST_ACCESS;
        else                            state_nxt_s = ST_SETTLE;
      end
      ST_ACCESS: begin
        if (!wb_cyc_i) begin
          state_nxt_s = ST_HOLD;
        end else if (!mapped_r || (!ack_hit_s && (cnt_r == ACK_LAST))) begin
          state_nxt_s = ST_RESP;
          resp_err_s  = 1'b1;
        end else if (ack_hit_s) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      ST_RESP: state_nxt_s = ST_HOLD;
      ST_HOLD: begin
        if (load_s)                  state_nxt_s = ST_ACCESS;
        else if (cnt_r == HOLD_LAST) state_nxt_s = ST_IDLE;
        else                         state_nxt_s = ST_HOLD;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output next-values; a request taken in HOLD is forwarded straight from the bus.
  always_comb begin
    halt_nxt_s = (state_nxt_s != ST_IDLE);
    resp_nxt_s = (state_nxt_s == ST_RESP);
    if (state_nxt_s == ST_ACCESS) begin
      stb_nxt_s   = load_s ? dec_vec_s : vec_r;
      we_nxt_s    = load_s ? wb_we_i : we_r;
      addr_nxt_s  = {20'd0, (load_s ? wb_addr_i[OFFSET_W-1:0] : addr_r)};
      wdata_nxt_s = load_s ? wb_data_i : wdata_r;
    end else begin
      stb_nxt_s   = '0;
      we_nxt_s    = 1'b0;
      addr_nxt_s  = 32'd0;
      wdata_nxt_s = 32'd0;
    end
    if (resp_nxt_s && !resp_err_s && !we_r) rdata_nxt_s = rd_data_s;
    else                                    rdata_nxt_s = 32'd0;
`ifdef BACKDOOR_ERR_EN
    ack_nxt_s = resp_nxt_s && !resp_err_s;
    err_nxt_s = resp_nxt_s && resp_err_s;
`else
    ack_nxt_s = resp_nxt_s;
`endif
  end

  // State, saturating counter and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      halt         <= 1'b0;
      wb_ack_o     <= 1'b0;
      wb_data_o    <= 32'd0;
      tgt_cyc_o    <= '0;
      tgt_strobe_o <= '0;
      tgt_we_o     <= 1'b0;
      tgt_addr_o   <= 32'd0;
      tgt_data_o   <= 32'd0;
`ifdef BACKDOOR_ERR_EN
      wb_err_o     <= 1'b0;
`endif
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= (state_nxt_s != state_r) ? '0 : sat_inc(cnt_r);
      halt         <= halt_nxt_s;
      wb_ack_o     <= ack_nxt_s;
      wb_data_o    <= rdata_nxt_s;
      tgt_cyc_o    <= stb_nxt_s;
      tgt_strobe_o <= stb_nxt_s;
      tgt_we_o     <= we_nxt_s;
      tgt_addr_o   <= addr_nxt_s;
      tgt_data_o   <= wdata_nxt_s;
`ifdef BACKDOOR_ERR_EN
      wb_err_o     <= err_nxt_s;
`endif
    end
  end

  // Request capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_r   <= '0;
      we_r     <= 1'b0;
      wdata_r  <= 32'd0;
      vec_r    <= '0;
      mapped_r <= 1'b0;
    end else if (load_s) begin
      addr_r   <= wb_addr_i[OFFSET_W-1:0];
      we_r     <= wb_we_i;
      wdata_r  <= wb_data_i;
      vec_r    <= dec_vec_s;
      mapped_r <= dec_mapped_s;
    end else begin
      addr_r   <= addr_r;
      we_r     <= we_r;
      wdata_r  <= wdata_r;
      vec_r    <= vec_r;
      mapped_r <= mapped_r;
    end
  end

endmodule

// File: tb/tb_backdoor_ctrl.sv
// Self-checking bench for backdoor_ctrl: randomized host accesses against a
// rule-level timing/data model; host, sync source and targets are driven in-line.
module tb_backdoor_ctrl;

  localparam int NUM_ROM = 5;
  localparam int NUM_RAM = 2;
  localparam int N       = NUM_ROM + NUM_RAM;
  localparam int SETTLE  = 8;
  localparam int SYNC_TO = 64;
  localparam int ACK_TO  = 32;
  localparam int BOUND   = 200;
`ifdef BACKDOOR_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset, sync, halt;
  logic wb_cyc_i, wb_strobe_i, wb_we_i, wb_ack_o;
  logic [31:0] wb_addr_i, wb_data_i, wb_data_o;
  logic [N-1:0] tgt_cyc_o, tgt_strobe_o, tgt_ack_i;
  logic tgt_we_o;
  logic [31:0] tgt_addr_o, tgt_data_o;
  logic [32*N-1:0] tgt_data_i;
`ifdef BACKDOOR_ERR_EN
  logic wb_err_o;
`endif

  int n_cmp, n_fail;
  logic [31:0] tgt_rdata [N];

  // observations of the latest access
  int obs_ack_edge, obs_resp_cnt, obs_max_pop, obs_first_stb, obs_first_sync;
  logic obs_ack, obs_err, obs_halt_low, obs_early_stb, obs_tw;
  logic [31:0] obs_data, obs_ta, obs_td;
  logic [N-1:0] obs_stb_or;

  backdoor_ctrl dut (
    .clock(clock), .reset(reset), .sync(sync), .halt(halt),
    .wb_cyc_i(wb_cyc_i), .wb_strobe_i(wb_strobe_i), .wb_we_i(wb_we_i),
    .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .wb_data_o(wb_data_o), .wb_ack_o(wb_ack_o),
`ifdef BACKDOOR_ERR_EN
    .wb_err_o(wb_err_o),
`endif
    .tgt_cyc_o(tgt_cyc_o), .tgt_strobe_o(tgt_strobe_o), .tgt_we_o(tgt_we_o),
    .tgt_addr_o(tgt_addr_o), .tgt_data_o(tgt_data_o),
    .tgt_data_i(tgt_data_i), .tgt_ack_i(tgt_ack_i)
  );

  always #5 clock = ~clock;

  function automatic int exp_target(input logic [31:0] a);
    int nib;
    nib = int'(a[15:12]);
    if (nib < NUM_ROM) return nib;
    else if (nib >= 8 && nib < 8 + NUM_RAM) return NUM_ROM + nib - 8;
    else return -1;
  endfunction

  // Edge (counted from the edge that samples the request) at which the response appears.
  function automatic int exp_ack_edge(input bit from_hold, input int first_sync,
                                      input int tgt, input bit mute, input int lat);
    int acc, j;
    if (from_hold) begin
      acc = 1;
    end else begin
      j = (first_sync != 0 && first_sync - 1 <= SYNC_TO) ? first_sync - 1 : SYNC_TO;
      acc = 1 + j + SETTLE;
    end
    if (tgt < 0) return acc + 1;
    if (mute) return acc + ACK_TO;
    return acc + lat;
  endfunction

  function automatic logic [31:0] exp_data(input int tgt, input bit we, input bit mute);
    if (we || tgt < 0 || mute) return 32'd0;
    return tgt_rdata[tgt];
  endfunction

  task automatic load_targets();
    for (int k = 0; k < N; k++) begin
      tgt_rdata[k] = $urandom();
      tgt_data_i[32*k +: 32] = tgt_rdata[k];
    end
  endtask

  // Drives one host access and plays sync source plus target responders.
  task automatic do_access(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           input int lat, input bit mute, input bit spur, input bit sync_on,
                           input int phase, input bit abort_on_stb);
    int sc;
    obs_ack_edge = 0; obs_resp_cnt = 0; obs_max_pop = 0; obs_first_stb = 0; obs_first_sync = 0;
    obs_ack = 1'b0; obs_err = 1'b0; obs_halt_low = 1'b0; obs_early_stb = 1'b0; obs_tw = 1'b0;
    obs_data = 32'd0; obs_ta = 32'd0; obs_td = 32'd0; obs_stb_or = '0;
    sc = 0;
    wb_cyc_i = 1'b1; wb_strobe_i = 1'b1; wb_we_i = we; wb_addr_i = addr; wb_data_i = wdata;
    tgt_ack_i = '0;
    sync = sync_on && (((1 + phase) % 8) == 0);
    for (int n = 1; n <= BOUND; n++) begin
      logic resp, err_now;
      @(posedge clock);
      if (sync && obs_first_sync == 0 && n >= 2) obs_first_sync = n;
      #1;
`ifdef BACKDOOR_ERR_EN
      err_now = wb_err_o;
`else
      err_now = 1'b0;
`endif
      if (!halt) obs_halt_low = 1'b1;
      if (|tgt_strobe_o) begin
        if (obs_first_stb == 0) obs_first_stb = n;
        if (!halt) obs_early_stb = 1'b1;
        obs_stb_or = obs_stb_or | tgt_strobe_o;
        if ($countones(tgt_strobe_o) > obs_max_pop) obs_max_pop = $countones(tgt_strobe_o);
        obs_tw = tgt_we_o; obs_ta = tgt_addr_o; obs_td = tgt_data_o;
        sc++;
        if (abort_on_stb) return;
      end
      resp = wb_ack_o | err_now;
      if (resp) begin
        obs_resp_cnt++;
        if (obs_ack_edge == 0) begin
          obs_ack_edge = n; obs_data = wb_data_o; obs_ack = wb_ack_o; obs_err = err_now;
        end
      end
      if (obs_ack_edge != 0) begin
        wb_cyc_i = 1'b0; wb_strobe_i = 1'b0;
      end
      if (obs_ack_edge != 0 && n >= obs_ack_edge + 1) break;
      tgt_ack_i = ((|tgt_strobe_o) && !mute && sc >= lat) ? tgt_strobe_o : '0;
      if (spur && (|tgt_strobe_o)) tgt_ack_i = tgt_ack_i | ~tgt_strobe_o;
      sync = sync_on && (((n + 1 + phase) % 8) == 0);
    end
    tgt_ack_i = '0; sync = 1'b0; wb_cyc_i = 1'b0; wb_strobe_i = 1'b0;
  endtask

  task automatic idle_until_halt_low(output int cnt);
    cnt = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock); #1;
      if (!halt) begin
        cnt = k;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; sync = 1'b0; wb_cyc_i = 1'b0; wb_strobe_i = 1'b0; wb_we_i = 1'b0;
    wb_addr_i = 32'd0; wb_data_i = 32'd0; tgt_ack_i = '0; tgt_data_i = '0;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if (halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt got %b exp 0", halt); end
    n_cmp++; if (wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b exp 0", wb_ack_o); end
    n_cmp++; if (wb_data_o !== 32'd0) begin n_fail++; $display("FAIL reset_data got %h exp 0", wb_data_o); end
    n_cmp++; if ({tgt_cyc_o, tgt_strobe_o, tgt_we_o} !== '0) begin
      n_fail++; $display("FAIL reset_tgt_ctl got %b exp 0", {tgt_cyc_o, tgt_strobe_o, tgt_we_o}); end
    n_cmp++; if ({tgt_addr_o, tgt_data_o} !== 64'd0) begin
      n_fail++; $display("FAIL reset_tgt_bus got %h exp 0", {tgt_addr_o, tgt_data_o}); end
    reset = 1'b1;
    @(posedge clock); #1;
    n_cmp++; if (halt !== 1'b0) begin n_fail++; $display("FAIL idle_halt got %b exp 0", halt); end
  endtask

  task automatic test_rom_read();
    int idle_n, e;
    load_targets();
    do_access(32'h0000_2010, 1'b0, 32'd0, 2, 1'b0, 1'b0, 1'b1, $urandom_range(0, 7), 1'b0);
    e = exp_ack_edge(1'b0, obs_first_sync, 2, 1'b0, 2);
    n_cmp++; if (obs_ack_edge !== e) begin n_fail++; $display("FAIL rom_ack_edge got %0d exp %0d", obs_ack_edge, e); end
    n_cmp++; if (obs_data !== tgt_rdata[2]) begin n_fail++; $display("FAIL rom_data got %h exp %h", obs_data, tgt_rdata[2]); end
    n_cmp++; if (obs_stb_or !== 7'b0000100) begin n_fail++; $display("FAIL rom_strobe got %b exp 0000100", obs_stb_or); end
    n_cmp++; if (obs_max_pop !== 1) begin n_fail++; $display("FAIL rom_onehot got %0d exp 1", obs_max_pop); end
    n_cmp++; if (obs_early_stb !== 1'b0) begin n_fail++; $display("FAIL rom_halt_first got %b exp 0", obs_early_stb); end
    n_cmp++; if (obs_resp_cnt !== 1) begin n_fail++; $display("FAIL rom_ack_len got %0d exp 1", obs_resp_cnt); end
    n_cmp++; if (obs_ta !== 32'h10) begin n_fail++; $display("FAIL rom_tgt_addr got %h exp 10", obs_ta); end
    n_cmp++; if (obs_ack !== 1'b1) begin n_fail++; $display("FAIL rom_ack got %b exp 1", obs_ack); end
    idle_until_halt_low(idle_n);
    n_cmp++; if (idle_n !== 16) begin n_fail++; $display("FAIL rom_hold_len got %0d exp 16", idle_n); end
  endtask

  task automatic test_ram_write();
    int idle_n, e, idx;
    logic [31:0] a, d, r;
    for (int i = 0; i < 3; i++) begin
      r = $urandom();
      idx = (i == 0) ? 1 : $urandom_range(0, NUM_RAM - 1);
      a = (i == 0) ? 32'h0000_9004 : {r[31:16], 4'(8 + idx), r[11:0]};
      d = (i == 0) ? 32'h7 : $urandom();
      do_access(a, 1'b1, d, $urandom_range(1, 3), 1'b0, 1'b0, 1'b1, $urandom_range(0, 7), 1'b0);
      e = exp_ack_edge(1'b0, obs_first_sync, NUM_ROM + idx, 1'b0, 1);
      n_cmp++; if (obs_stb_or !== 7'(1 << (NUM_ROM + idx))) begin
        n_fail++; $display("FAIL ram_strobe got %b exp bit %0d", obs_stb_or, NUM_ROM + idx); end
      n_cmp++; if (obs_tw !== 1'b1) begin n_fail++; $display("FAIL ram_we got %b exp 1", obs_tw); end
      n_cmp++; if (obs_ta !== {20'd0, a[11:0]}) begin n_fail++; $display("FAIL ram_addr got %h exp %h", obs_ta, {20'd0, a[11:0]}); end
      n_cmp++; if (obs_td !== d) begin n_fail++; $display("FAIL ram_wdata got %h exp %h", obs_td, d); end
      n_cmp++; if (obs_data !== 32'd0) begin n_fail++; $display("FAIL ram_rdata got %h exp 0", obs_data); end
      n_cmp++; if (obs_ack_edge < e) begin n_fail++; $display("FAIL ram_ack_early got %0d exp >= %0d", obs_ack_edge, e); end
      idle_until_halt_low(idle_n);
    end
  endtask

  task automatic test_unmapped();
    int idle_n, e;
    logic [31:0] a;
    logic [3:0] nibs [4];
    nibs[0] = 4'h5; nibs[1] = 4'hA; nibs[2] = 4'h7; nibs[3] = 4'hF;
    load_targets();
    for (int i = 0; i < 4; i++) begin
      a = {16'h0, nibs[i], 12'(i * 4)};
      do_access(a, 1'b0, 32'd0, 1, 1'b0, 1'b1, 1'b1, $urandom_range(0, 7), 1'b0);
      e = exp_ack_edge(1'b0, obs_first_sync, -1, 1'b0, 1);
      n_cmp++; if (obs_stb_or !== '0) begin n_fail++; $display("FAIL unmap_strobe got %b exp 0", obs_stb_or); end
      n_cmp++; if (obs_ack_edge !== e) begin n_fail++; $display("FAIL unmap_edge got %0d exp %0d", obs_ack_edge, e); end
      n_cmp++; if (obs_data !== 32'd0) begin n_fail++; $display("FAIL unmap_data got %h exp 0", obs_data); end
      n_cmp++; if ({obs_ack, obs_err} !== {!ERR_EN, ERR_EN}) begin
        n_fail++; $display("FAIL unmap_kind got ack=%b err=%b exp ack=%b err=%b", obs_ack, obs_err, !ERR_EN, ERR_EN); end
      idle_until_halt_low(idle_n);
    end
  endtask

  task automatic test_sync_timeout();
    int idle_n;
    load_targets();
    do_access(32'h0000_3000, 1'b0, 32'd0, 1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    n_cmp++; if (obs_first_stb !== 1 + SYNC_TO + SETTLE) begin
      n_fail++; $display("FAIL timeout_access_start got %0d exp %0d", obs_first_stb, 1 + SYNC_TO + SETTLE); end
    n_cmp++; if (obs_ack_edge !== 1 + SYNC_TO + SETTLE + ACK_TO) begin
      n_fail++; $display("FAIL timeout_abort_edge got %0d exp %0d", obs_ack_edge, 1 + SYNC_TO + SETTLE + ACK_TO); end
    n_cmp++; if (obs_data !== 32'd0) begin n_fail++; $display("FAIL timeout_data got %h exp 0", obs_data); end
    n_cmp++; if ({obs_ack, obs_err} !== {!ERR_EN, ERR_EN}) begin
      n_fail++; $display("FAIL timeout_kind got ack=%b err=%b", obs_ack, obs_err); end
    idle_until_halt_low(idle_n);
  endtask

  task automatic test_back_to_back();
    int idle_n, e, lat;
    load_targets();
    do_access(32'h0000_0100, 1'b0, 32'd0, 1, 1'b0, 1'b0, 1'b1, $urandom_range(0, 7), 1'b0);
    for (int i = 0; i < 3; i++) begin
      lat = $urandom_range(1, 4);
      do_access({16'h0, 4'(i + 1), 12'h0AC}, 1'b0, 32'd0, lat, 1'b0, 1'b0, 1'b1, 0, 1'b0);
      e = exp_ack_edge(1'b1, 0, i + 1, 1'b0, lat);
      n_cmp++; if (obs_ack_edge !== e) begin n_fail++; $display("FAIL b2b_ack_edge got %0d exp %0d", obs_ack_edge, e); end
      n_cmp++; if (obs_halt_low !== 1'b0) begin n_fail++; $display("FAIL b2b_halt_drop got %b exp 0", obs_halt_low); end
      n_cmp++; if (obs_data !== tgt_rdata[i+1]) begin n_fail++; $display("FAIL b2b_data got %h exp %h", obs_data, tgt_rdata[i+1]); end
    end
    idle_until_halt_low(idle_n);
    n_cmp++; if (idle_n !== 16) begin n_fail++; $display("FAIL b2b_hold_len got %0d exp 16", idle_n); end
  endtask

  task automatic test_random();
    int idle_n, e, tgt, lat;
    bit in_hold, from_hold, mute, we;
    logic [31:0] a, d;
    logic [N-1:0] ev;
    in_hold = 1'b0;
    for (int i = 0; i < 16; i++) begin
      load_targets();
      a = $urandom(); d = $urandom();
      we = 1'($urandom_range(0, 1)); lat = $urandom_range(1, 4);
      mute = ($urandom_range(0, 7) == 0);
      from_hold = in_hold && ($urandom_range(0, 1) == 1);
      if (in_hold && !from_hold) idle_until_halt_low(idle_n);
      tgt = exp_target(a);
      do_access(a, we, d, lat, mute, 1'($urandom_range(0, 1)), 1'b1, $urandom_range(0, 7), 1'b0);
      in_hold = 1'b1;
      e = exp_ack_edge(from_hold, obs_first_sync, tgt, mute, lat);
      ev = '0;
      if (tgt >= 0) ev[tgt] = 1'b1;
      n_cmp++; if (obs_ack_edge !== e) begin n_fail++; $display("FAIL rnd%0d_edge got %0d exp %0d", i, obs_ack_edge, e); end
      n_cmp++; if (obs_data !== exp_data(tgt, we, mute)) begin
        n_fail++; $display("FAIL rnd%0d_data got %h exp %h", i, obs_data, exp_data(tgt, we, mute)); end
      n_cmp++; if (obs_stb_or !== ev) begin n_fail++; $display("FAIL rnd%0d_strobe got %b exp %b", i, obs_stb_or, ev); end
      n_cmp++; if (obs_err !== (ERR_EN && (tgt < 0 || mute))) begin
        n_fail++; $display("FAIL rnd%0d_err got %b exp %b", i, obs_err, ERR_EN && (tgt < 0 || mute)); end
      if (tgt >= 0) begin
        n_cmp++; if ({obs_tw, obs_ta, obs_td} !== {we, 20'd0, a[11:0], d}) begin
          n_fail++; $display("FAIL rnd%0d_fwd got %b %h %h exp %b %h %h", i, obs_tw, obs_ta, obs_td, we, {20'd0, a[11:0]}, d); end
      end
    end
    idle_until_halt_low(idle_n);
  endtask

  task automatic test_reset_mid();
    int acks, e;
    load_targets();
    do_access(32'h0000_4040, 1'b0, 32'd0, 3, 1'b0, 1'b0, 1'b1, 3, 1'b1);
    n_cmp++; if (tgt_strobe_o !== 7'b0010000) begin n_fail++; $display("FAIL mid_reached_access got %b exp 0010000", tgt_strobe_o); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (halt !== 1'b0) begin n_fail++; $display("FAIL mid_async_halt got %b exp 0", halt); end
    n_cmp++; if ({tgt_cyc_o, tgt_strobe_o} !== '0) begin
      n_fail++; $display("FAIL mid_async_strobe got %b exp 0", {tgt_cyc_o, tgt_strobe_o}); end
    wb_cyc_i = 1'b0; wb_strobe_i = 1'b0; tgt_ack_i = '0; sync = 1'b0;
    acks = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      if (wb_ack_o) acks++;
    end
    n_cmp++; if (acks !== 0) begin n_fail++; $display("FAIL mid_no_ack got %0d exp 0", acks); end
    do_access(32'h0000_0FFC, 1'b0, 32'd0, 2, 1'b0, 1'b0, 1'b1, $urandom_range(0, 7), 1'b0);
    e = exp_ack_edge(1'b0, obs_first_sync, 0, 1'b0, 2);
    n_cmp++; if (obs_ack_edge !== e) begin n_fail++; $display("FAIL mid_next_edge got %0d exp %0d", obs_ack_edge, e); end
    n_cmp++; if (obs_data !== tgt_rdata[0]) begin n_fail++; $display("FAIL mid_next_data got %h exp %h", obs_data, tgt_rdata[0]); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_rom_read();
    test_ram_write();
    test_unmapped();
    test_sync_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/backdoor_ctrl.md
Name: backdoor_ctrl

Overview:
- Wishbone slave that gives a host debug port safe access to the ROM and RAM backdoor ports of the 4-bit system.
- On each access it freezes the CPU with `halt`, waits for an instruction-cycle boundary on `sync`, then routes one Wishbone transaction to the chip selected by the address.
- It returns the target's data and ack to the host, then releases `halt`.
- Sits beside `cpu`, the ROMs and the RAMs at system level; drives the shared `halt` net.

Parameters:
- NUM_ROM, 5, number of ROM backdoor targets (chip IDs 0..NUM_ROM-1).
- NUM_RAM, 2, number of RAM backdoor targets.
- SETTLE_CYCLES, 8, clocks held after halt-boundary detection before a target is touched (one 8-clock CPU cycle).
- SYNC_TIMEOUT, 64, clocks to wait for `sync` before proceeding anyway.
- ACK_TIMEOUT, 32, clocks to wait for a target ack before aborting.
- HOLD_CYCLES, 16, idle clocks `halt` stays asserted after a response, so back-to-back host accesses skip re-synchronisation.

Ports:
- clock, input, 1, system clock.
- reset, input, 1, asynchronous active-low reset (0 = in reset).
- sync, input, 1, CPU cycle-start marker.
- halt, output, 1, CPU/ROM/RAM freeze request.
- wb_cyc_i, input, 1, host cycle.
- wb_strobe_i, input, 1, host strobe.
- wb_we_i, input, 1, host write enable.
- wb_addr_i, input, 32, [15:12] target select, [11:0] offset.
- wb_data_i, input, 32, host write data.
- wb_data_o, output, 32, host read data.
- wb_ack_o, output, 1, host ack.
- tgt_cyc_o, output, NUM_ROM+NUM_RAM, per-target cyc, one-hot.
- tgt_strobe_o, output, NUM_ROM+NUM_RAM, per-target strobe, one-hot.
- tgt_we_o, output, 1, shared write enable.
- tgt_addr_o, output, 32, shared address with bits [31:12] zeroed.
- tgt_data_o, output, 32, shared write data.
- tgt_data_i, input, 32*(NUM_ROM+NUM_RAM), flattened target read data; target k in bits [32k+31:32k].
- tgt_ack_i, input, NUM_ROM+NUM_RAM, per-target ack.

Behaviour:

Reset values (whenever reset=0, asynchronously):
- halt=0, wb_ack_o=0, wb_data_o=0, all tgt_* outputs 0.
- FSM=IDLE, all counters 0.
- A reset in the middle of an access simply drops it; no ack is issued.

Address decode on wb_addr_i[15:12]:
- 0..NUM_ROM-1 selects ROM index = value.
- 8..8+NUM_RAM-1 selects RAM index = NUM_ROM + (value-8).
- Any other value is unmapped.

FSM states and transitions:
- IDLE: on wb_cyc_i & wb_strobe_i, latch addr/we/data/target; set halt=1; go to SYNC_WAIT.
- SYNC_WAIT: leave on the first `sync`=1 sampled while halt=1, or when the counter reaches SYNC_TIMEOUT. Go to SETTLE.
- SETTLE: count SETTLE_CYCLES, then go to ACCESS.
- ACCESS:
  - If the target is mapped, assert the selected tgt_cyc_o/tgt_strobe_o bit.
  - On that target's ack, register its tgt_data_i slice and go to RESP. The strobe drops in the same cycle the ack is sampled.
  - If the target is unmapped, go to RESP immediately with data 0.
  - If ACK_TIMEOUT expires, drop the strobe and go to RESP with data 0.
- RESP: wb_ack_o=1 for exactly one clock; wb_data_o holds the latched data (0 for writes); go to HOLD.
- HOLD:
  - halt stays 1.
  - A new host request goes directly to SETTLE-free ACCESS (latency = decode + target ack).
  - After HOLD_CYCLES idle clocks, halt=0 and go to IDLE.

Host and bus rules:
- If wb_cyc_i deasserts in SYNC_WAIT, SETTLE or ACCESS: drop all target strobes, no ack, go to HOLD.
- wb_strobe_i is ignored in RESP.
- Minimum read latency from IDLE: 1 + (clocks to sync) + SETTLE_CYCLES + target ack latency + 1.
- Only one target is strobed at any time. An ack on a non-selected target is ignored.
- Counters are saturating; none of them wraps.

Optional Feature:
- Macro: BACKDOOR_ERR_EN.
- Enabled: adds output port wb_err_o (1 bit, reset 0). An unmapped address or an ack timeout produces wb_err_o=1 for one clock in RESP instead of wb_ack_o; wb_data_o=0.
- Disabled: no wb_err_o port; both cases complete with wb_ack_o and data 0.

Decomposition:
- Shared package backdoor_pkg:
  - FSM state encoding (IDLE, SYNC_WAIT, SETTLE, ACCESS, RESP, HOLD).
  - Select constants ROM_SEL_BASE=4'h0, RAM_SEL_BASE=4'h8.
  - Offset width 12.
- One natural sub-module: backdoor_decode, a combinational map from address nibble to one-hot target vector plus mapped flag.

Test Plan:
- Read ROM 2: addr 0x0000_2010; sync pulses every 8 clocks; target 2 acks with 0x0000_00A5 after 2 clocks. Required: halt=1 before any strobe; exactly one tgt_strobe_o bit set (bit 2); wb_ack_o one clock with data 0x0000_00A5; halt=0 after 16 idle clocks.
- Write RAM 1: addr 0x0000_9004, data 0x7. Required: tgt_strobe_o bit 6 set, tgt_we_o=1, tgt_addr_o=0x004, tgt_data_o=0x7; wb_data_o=0.
- Unmapped addr 0x0000_5000. Required: no tgt strobe; ack (or wb_err_o with BACKDOOR_ERR_EN) with data 0.
- sync held low. Required: ACCESS starts after 64+8 clocks. Target never acks: abort after 32 clocks, response data 0.
- Back-to-back reads within HOLD_CYCLES. Required: halt stays 1 throughout; second access has no SETTLE delay.
- reset pulled low during ACCESS. Required: halt and tgt strobes go to 0 immediately and asynchronously; no wb_ack_o; next request is handled normally.
